// File: rtl/esas_sqrt_if.sv
// ---------------------------------------------------------------------------
// esas_sqrt_if
// Stream bundle for the ESAS square-root pipeline: an operand channel
// (valid/ready plus operand and compensation enable) and a result channel
// (valid/ready plus result and zero flag).
//
// Signals
//   in_valid    operand present (source -> pipe)
//   in_ready    pipe can accept an operand this cycle (pipe -> source)
//   in_data     unsigned operand, IN_W bits
//   in_comp_en  apply odd-exponent compensation to this operand
//   out_valid   result present (pipe -> consumer)
//   out_ready   consumer accepts the result this cycle (consumer -> pipe)
//   out_data    approximate square root, OUT_W bits
//   out_zero    operand was zero
//
// Modports
//   master  the testbench / surrounding logic driving operands and
//           consuming results
//   slave   the square-root pipeline itself
// ---------------------------------------------------------------------------
interface esas_sqrt_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = IN_W / 2
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_comp_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid,
    output in_data,
    output in_comp_en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_comp_en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_zero
  );

endinterface

// File: rtl/esas_sqrt_pipe.sv
// ---------------------------------------------------------------------------
// esas_sqrt_pipe
// Four-stage pipelined integer square-root approximator (ESAS method).
// Each accepted operand is normalised to a leading-one position k and an
// MW-bit fraction f, the fraction gets a log-linear correction, the
// exponent is halved and the mantissa re-biased to 1 + f'/2, odd exponents
// optionally get a sqrt(2) factor (1 + 1/4 + 1/8 + 1/32), and finally the
// mantissa is shifted back into integer position and saturated to OUT_W.
// One operand per clock, four cycles from accept to out_valid; a stalled
// consumer freezes the whole pipe.
//
// Parameters
//   IN_W   operand width, even, 4..64
//   OUT_W  result width (IN_W/2)
//   MW     mantissa fraction width
//   LN_K   correction subtracted from f when its MSB is set
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every stage
//   bus    esas_sqrt_if slave: operand channel in, result channel out
// ---------------------------------------------------------------------------
module esas_sqrt_pipe #(
  parameter int            IN_W  = 32,
  parameter int            OUT_W = IN_W / 2,
  parameter int            MW    = 16,
  parameter logic [MW-1:0] LN_K  = 16'h2BF4
) (
  input  logic       clk,
  input  logic       rst_n,
  esas_sqrt_if.slave bus
);

  // Width of the leading-one index k (0..IN_W-1).
  localparam int KW = $clog2(IN_W);
  // Mantissa after optional compensation; the sqrt(2) factor stays below 2.
  localparam int CW = MW + 1;
  // Shifted result before saturation; the left shift never exceeds IN_W/2.
  localparam int RW = CW + IN_W / 2;
  // Shift-count arithmetic width, with headroom so IN_W=64 cannot wrap.
  localparam int SW = $clog2(RW) + 2;

  if ((IN_W % 2) != 0 || IN_W < 4 || IN_W > 64) begin : g_bad_in_w
    $error("esas_sqrt_pipe: IN_W must be even and in the range 4..64");
  end

  // -------------------------------------------------------------------------
  // Flow control: every stage moves together; the pipe only holds when a
  // result is sitting at the output and the consumer refuses it.
  // -------------------------------------------------------------------------
  logic adv;
  logic out_valid_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // -------------------------------------------------------------------------
  // Stage 1 combinational: leading-one detection and fraction extraction.
  // -------------------------------------------------------------------------
  logic [KW-1:0] msb_idx;
  logic [KW-1:0] norm_sh;
  logic [MW-1:0] frac_in;
  logic          zero_in;

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.in_data[i]) begin
        msb_idx = KW'(i);
      end
    end
  end

  // Shift the leading one up to the top of an (IN_W+MW)-bit field padded
  // with zeros, then bring it down to bit MW so the MW bits just below it
  // land in the fraction; the cast drops the leading one itself.
  assign norm_sh = KW'(IN_W - 1) - msb_idx;
  assign frac_in = MW'(({bus.in_data, {MW{1'b0}}} << norm_sh) >> (IN_W - 1));
  assign zero_in = (bus.in_data == '0);

  logic          v1;
  logic          z1;
  logic          cmp1;
  logic [KW-1:0] k1;
  logic [MW-1:0] f1;

  // Stage 1 register: capture k, f and the zero flag; a zero operand
  // forces k and f to zero so later stages see a clean value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      z1   <= 1'b0;
      cmp1 <= 1'b0;
      k1   <= '0;
      f1   <= '0;
    end else if (adv) begin
      v1   <= bus.in_valid;
      z1   <= zero_in;
      cmp1 <= bus.in_comp_en;
      k1   <= zero_in ? '0 : msb_idx;
      f1   <= zero_in ? '0 : frac_in;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: log-linear correction of the upper half of the fraction range.
  // -------------------------------------------------------------------------
  logic [MW-1:0] f_corr;

  assign f_corr = f1[MW-1] ? (f1 - LN_K) : f1;

  logic          v2;
  logic          z2;
  logic          cmp2;
  logic [KW-1:0] k2;
  logic [MW-1:0] f2;

  // Stage 2 register: corrected fraction travels with k and the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      z2   <= 1'b0;
      cmp2 <= 1'b0;
      k2   <= '0;
      f2   <= '0;
    end else if (adv) begin
      v2   <= v1;
      z2   <= z1;
      cmp2 <= cmp1;
      k2   <= k1;
      f2   <= f_corr;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: halve the exponent and re-bias the mantissa to 1 + f'/2 in
  // Q1.(MW-1); the low exponent bit records whether sqrt(2) is missing.
  // -------------------------------------------------------------------------
  logic          v3;
  logic          z3;
  logic          cmp3;
  logic          odd3;
  logic [KW-1:0] e3;
  logic [MW-1:0] m3;

  // Stage 3 register: mantissa, halved exponent and odd flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      z3   <= 1'b0;
      cmp3 <= 1'b0;
      odd3 <= 1'b0;
      e3   <= '0;
      m3   <= '0;
    end else if (adv) begin
      v3   <= v2;
      z3   <= z2;
      cmp3 <= cmp2;
      odd3 <= k2[0];
      e3   <= k2 >> 1;
      m3   <= MW'({1'b1, f2} >> 1);
    end
  end

  // -------------------------------------------------------------------------
  // Stage 4 combinational: sqrt(2) compensation, denormalise, saturate.
  // -------------------------------------------------------------------------
  logic [CW-1:0]    m_ext;
  logic [CW-1:0]    comp_val;
  logic [SW-1:0]    e_ext;
  logic [SW-1:0]    mw_top;
  logic [RW-1:0]    c_wide;
  logic [RW-1:0]    r_wide;
  logic             sat;
  logic [OUT_W-1:0] res;

  always_comb begin
    m_ext    = {1'b0, m3};
    comp_val = (odd3 && cmp3)
               ? (m_ext + (m_ext >> 2) + (m_ext >> 3) + (m_ext >> 5))
               : m_ext;
    e_ext    = SW'(e3);
    mw_top   = SW'(MW - 1);
    c_wide   = RW'(comp_val);
    // The mantissa carries MW-1 fractional bits, so an exponent of MW-1
    // means no shift; below that the fraction is truncated away, above it
    // the value is scaled up.
    if (e_ext <= mw_top) begin
      r_wide = c_wide >> (mw_top - e_ext);
    end else begin
      r_wide = c_wide << (e_ext - mw_top);
    end
    sat = |r_wide[RW-1:OUT_W];
    if (z3) begin
      res = '0;
    end else if (sat) begin
      res = '1;
    end else begin
      res = r_wide[OUT_W-1:0];
    end
  end

  logic [OUT_W-1:0] out_data_q;
  logic             out_zero_q;

  // Output register: only loads on advance, so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= v3;
      out_data_q  <= res;
      out_zero_q  <= z3;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_esas_sqrt_pipe.sv
// ---------------------------------------------------------------------------
// tb_esas_sqrt_pipe
// Scoreboard bench for esas_sqrt_pipe at default parameters. The driver
// pushes an expected result for every accepted operand; an independent
// monitor pops and compares whenever a result is handed over, and also
// watches in_ready, output stability during stalls and latency.
// ---------------------------------------------------------------------------
module tb_esas_sqrt_pipe;

  localparam int IN_W     = 32;
  localparam int OUT_W    = IN_W / 2;
  localparam int MAX_WAIT = 200;
  localparam int N_DIR    = 18;

  logic clk;
  logic rst_n;

  esas_sqrt_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  esas_sqrt_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             zero;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  bit   lat_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors with hand-derived results (default MW=16, LN_K=2BF4).
  // e.g. 1000000: k=19, f=E848, f'=BC54, m=DE2A, comp -> 1386A, >>6 = 4E1.
  // FFFFFFFF: k=31, f'=D40B, m=EA05, comp -> 14916 saturates to FFFF.
  logic [IN_W-1:0]  dir_a [N_DIR] = '{32'h0, 32'h1, 32'h4, 32'h10000,
                                      32'h2, 32'h8, 32'h8, 32'hFFFFFFFF,
                                      32'h3, 32'h5, 32'd100, 32'd1000000,
                                      32'd1000000, 32'hFFFF, 32'h40000000,
                                      32'h80000000, 32'h80000000, 32'hFFFFFFFF};
  logic             dir_c [N_DIR] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [OUT_W-1:0] dir_d [N_DIR] = '{16'h0, 16'h1, 16'h2, 16'h100,
                                      16'h1, 16'h2, 16'h2, 16'hFFFF,
                                      16'h1, 16'h2, 16'd11, 16'd1249,
                                      16'd888, 16'd329, 16'h8000,
                                      16'hB400, 16'h8000, 16'hEA05};
  logic             dir_z [N_DIR] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Arithmetic reference for random operands, written in plain integer
  // terms: result = floor(c * 2^(k/2) / 2^15).
  function automatic logic [OUT_W:0] modelSqrt(input logic [IN_W-1:0] a, input logic comp);
    longint unsigned f;
    longint unsigned m;
    longint unsigned c;
    longint unsigned r;
    int k;
    if (a == '0) return {1'b1, {OUT_W{1'b0}}};
    k = 0;
    for (int i = 0; i < IN_W; i++) if (a[i]) k = i;
    f = (({32'b0, a} << 16) >> k) & 64'hFFFF;
    if (f >= 64'h8000) f = f - 64'h2BF4;
    m = 64'h8000 + f / 2;
    c = ((k % 2) == 1 && comp) ? (m + m / 4 + m / 8 + m / 32) : m;
    r = (c << (k / 2)) >> 15;
    if (r > 64'hFFFF) r = 64'hFFFF;
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  function automatic logic [IN_W-1:0] randOperand();
    logic [IN_W-1:0] a;
    a = $urandom;
    return a >> $urandom_range(0, IN_W - 1);
  endfunction

  // ready_mode: 0 consumer always ready, 1 random, 2 never ready
  task automatic applyStimulus(input logic [IN_W-1:0] a, input logic comp,
                               input logic [OUT_W-1:0] ed, input logic ez,
                               input int ready_mode);
    int   tries = 0;
    bit   done  = 1'b0;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_data    = a;
      bus.in_comp_en = comp;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      #4;
      if (bus.in_ready) begin
        e.data    = ed;
        e.zero    = ez;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        done = 1'b1;
      end else if (++tries > MAX_WAIT) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL accept_timeout: in_ready stuck low for operand %0h", a);
        done = 1'b1;
      end
    end
  endtask

  task automatic idleCycle(input bit rand_ready);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic waitDrain();
    int n = 0;
    idleCycle(1'b0);
    while (exp_q.size() != 0 && n < MAX_WAIT) begin
      idleCycle(1'b0);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results still owed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge, so a valid &&
  // ready seen here is the handshake that edge completes.
  logic             prev_stall = 1'b0;
  logic [OUT_W:0]   prev_out   = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        checkOutput("in_ready_adv", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (prev_stall) begin
          checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
          checkOutput("stall_hold", 64'({bus.out_zero, bus.out_data}), 64'(prev_out));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_out: got %0h with no operand outstanding", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", 64'(bus.out_data), 64'(e.data));
            checkOutput("out_zero", 64'(bus.out_zero), 64'(e.zero));
            if (lat_check) checkOutput("latency", 64'(cyc - e.acc_cyc), 64'd4);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = {bus.out_zero, bus.out_data};
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IN_W-1:0] a;
    logic            comp;
    logic [OUT_W:0]  m;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_comp_en = 1'b0;
    bus.out_ready  = 1'b1;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("reset_out_zero", 64'(bus.out_zero), 64'd0);
    rst_n = 1'b1;

    // Directed vectors back to back with the consumer always ready.
    $display("[TB] directed vectors");
    lat_check = 1'b1;
    for (int i = 0; i < N_DIR; i++) begin
      applyStimulus(dir_a[i], dir_c[i], dir_d[i], dir_z[i], 0);
    end
    waitDrain();

    // Continuous stream: one result per clock, each exactly 4 cycles late.
    $display("[TB] random stream, consumer always ready");
    for (int i = 0; i < 100; i++) begin
      a    = randOperand();
      comp = 1'($urandom_range(0, 1));
      m    = modelSqrt(a, comp);
      applyStimulus(a, comp, m[OUT_W-1:0], m[OUT_W], 0);
    end
    waitDrain();

    // Random back-pressure and gaps; latency is no longer fixed.
    $display("[TB] random stream with back-pressure");
    lat_check = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle(1'b1);
      a    = randOperand();
      comp = 1'($urandom_range(0, 1));
      m    = modelSqrt(a, comp);
      applyStimulus(a, comp, m[OUT_W-1:0], m[OUT_W], 1);
    end
    waitDrain();

    // Fill the pipe with the consumer stalled, then reset mid-flight.
    $display("[TB] reset with operands in flight");
    for (int i = 0; i < 4; i++) begin
      a = randOperand();
      m = modelSqrt(a, 1'b1);
      applyStimulus(a, 1'b1, m[OUT_W-1:0], m[OUT_W], 2);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    checkOutput("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_drop_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_drop_data", 64'(bus.out_data), 64'd0);
    checkOutput("async_drop_zero", 64'(bus.out_zero), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_reset_idle", 64'(bus.out_valid), 64'd0);

    // The pipe must work normally again after the flush.
    lat_check = 1'b1;
    applyStimulus(32'h4, 1'b1, 16'h2, 1'b0, 0);
    applyStimulus(32'h0, 1'b0, 16'h0, 1'b1, 0);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
